// File: rtl/picorv32_mem_pkg.sv
// Shared types and helpers for the PicoRV32 memory responder.
package picorv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic [31:0] TOHOST_DEFAULT = 32'h1000_0000;

    // Take each byte lane from new_word where its strobe is set, else keep old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wstrb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = wstrb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying two pseudo-random stall bits.
module mem_stall_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [1:0] stall
);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (advance) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = lfsr[1:0];

endmodule

// File: rtl/picorv32_mem_responder.sv
// PicoRV32 native-interface memory slave with wait states, OOB flag, tohost mailbox and backdoor load.
module picorv32_mem_responder
    import picorv32_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          RAND_STALL  = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err_oob,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(MEM_WORDS);

    resp_state_t state;
    logic [4:0]    wait_cnt;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_wstrb;
    logic          lat_instr;
    logic          lat_ram;
    logic          lat_tohost;

    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   ram_q;
    logic [1:0]    stall;

    logic [29:0]   off_word;
    logic          in_ram;
    logic          hit_tohost;
    logic [4:0]    start_wait;
    logic          accept;
    logic          rd_en;
    logic [AW-1:0] rd_idx;
    logic          commit;
    logic          load_ok;

    assign off_word   = mem_addr[31:2] - ADDR_BASE[31:2];
    assign in_ram     = (mem_addr >= ADDR_BASE) && ({2'b00, off_word} < 32'(MEM_WORDS));
    assign hit_tohost = (mem_addr[31:2] == TOHOST_ADDR[31:2]);
    assign start_wait = 5'(WAIT_STATES) + (RAND_STALL ? {3'b000, stall} : 5'd0);
    assign accept     = (state == IDLE) && mem_valid;

    // The single read port fires on the edge that enters RESP; the same word feeds the store merge.
    assign rd_en   = (accept && (start_wait == 5'd0)) || ((state == WAIT) && (wait_cnt == 5'd1));
    assign rd_idx  = (state == IDLE) ? off_word[AW-1:0] : lat_idx;
    assign commit  = !reset && (state == RESP) && lat_ram && (lat_wstrb != 4'b0000);
    assign load_ok = load_en && (state == IDLE) && !mem_valid && (load_addr < 32'(MEM_WORDS));

    mem_stall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .stall   (stall)
    );

    always_ff @(posedge clk) begin
        if (commit) begin
            ram[lat_idx] <= merge_bytes(ram_q, lat_wdata, lat_wstrb);
        end else if (load_ok) begin
            ram[load_addr[AW-1:0]] <= load_data;
        end
        if (rd_en) begin
            ram_q <= ram[rd_idx];
        end
    end

    // Mailbox and out-of-range reads return zero.
    assign mem_rdata = (mem_ready && lat_ram) ? ram_q : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= 5'd0;
            mem_ready    <= 1'b0;
            err_oob      <= 1'b0;
            tohost_valid <= 1'b0;
            tohost_data  <= 32'h0;
            fetch_count  <= 32'h0;
            lat_idx      <= '0;
            lat_wdata    <= 32'h0;
            lat_wstrb    <= 4'b0000;
            lat_instr    <= 1'b0;
            lat_ram      <= 1'b0;
            lat_tohost   <= 1'b0;
        end else begin
            mem_ready    <= 1'b0;
            tohost_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        lat_idx    <= off_word[AW-1:0];
                        lat_wdata  <= mem_wdata;
                        lat_wstrb  <= mem_wstrb;
                        lat_instr  <= mem_instr;
                        lat_ram    <= in_ram && !hit_tohost;
                        lat_tohost <= hit_tohost;
                        wait_cnt   <= start_wait;
                        if (start_wait == 5'd0) begin
                            state     <= RESP;
                            mem_ready <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 5'd1;
                    if (wait_cnt == 5'd1) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (!lat_ram && !lat_tohost) begin
                        err_oob <= 1'b1;
                    end
                    if (lat_tohost && (lat_wstrb != 4'b0000)) begin
                        tohost_data  <= merge_bytes(tohost_data, lat_wdata, lat_wstrb);
                        tohost_valid <= 1'b1;
                    end
                    if (lat_instr && (fetch_count != 32'hFFFF_FFFF)) begin
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
